// File: rtl/regfile_wr_arbiter_if.sv
// Request/response bundle between the write-back stage, the debug unit and the
// register-file write arbiter.
interface regfile_wr_arbiter_if #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5
);
   logic               i_WB_reg_write;
   logic [NB_REG-1:0]  i_WB_selected_reg;
   logic [NB_DATA-1:0] i_WB_selected_data;

   // Debug handshake: an entry transfers on a rising clock edge where
   // i_dbg_valid and o_dbg_ready are both 1. Ready depends only on buffer
   // occupancy, never on valid. Valid may be raised or dropped freely.
   logic               i_dbg_valid;
   logic [NB_REG-1:0]  i_dbg_reg;
   logic [NB_DATA-1:0] i_dbg_data;
   logic               o_dbg_ready;

   logic               o_rf_write;
   logic [NB_REG-1:0]  o_rf_reg;
   logic [NB_DATA-1:0] o_rf_data;
   logic               o_pipe_stall;

   modport master (
      output i_WB_reg_write, i_WB_selected_reg, i_WB_selected_data,
      output i_dbg_valid, i_dbg_reg, i_dbg_data,
      input  o_dbg_ready, o_rf_write, o_rf_reg, o_rf_data, o_pipe_stall
   );

   modport slave (
      input  i_WB_reg_write, i_WB_selected_reg, i_WB_selected_data,
      input  i_dbg_valid, i_dbg_reg, i_dbg_data,
      output o_dbg_ready, o_rf_write, o_rf_reg, o_rf_data, o_pipe_stall
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Merges pipeline write-back and buffered debug writes onto one register-file
// write port; a debug write starved for too long forces a one-cycle stall.
module regfile_wr_arbiter #(
   parameter int NB_DATA  = 32,
   parameter int NB_REG   = 5,
   parameter int MAX_WAIT = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   regfile_wr_arbiter_if.slave  bus,
   output logic [1:0]           o_fsm_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      FORCE   = 2'd2
   } state_t;

   // Counter value at which one more pipeline win triggers the forced stall.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 2);

   state_t             state, state_next;
   logic [1:0]         count, count_next;
   logic [7:0]         wait_cnt, wait_next;
   logic [NB_REG-1:0]  fifo_reg  [2];
   logic [NB_DATA-1:0] fifo_data [2];

   logic               push, pop, wr_hi;
   logic               grant_valid, grant_pipe;
   logic [NB_REG-1:0]  grant_reg;
   logic [NB_DATA-1:0] grant_data;

   logic               rf_write_q, pipe_stall_q;
   logic [NB_REG-1:0]  rf_reg_q;
   logic [NB_DATA-1:0] rf_data_q;

   assign bus.o_dbg_ready  = (count != 2'd2);
   assign push             = bus.i_dbg_valid & bus.o_dbg_ready;
   assign bus.o_rf_write   = rf_write_q;
   assign bus.o_rf_reg     = rf_reg_q;
   assign bus.o_rf_data    = rf_data_q;
   assign bus.o_pipe_stall = pipe_stall_q;
   assign o_fsm_state      = state;

   always_comb begin
      state_next  = state;
      grant_valid = 1'b0;
      grant_pipe  = 1'b0;
      pop         = 1'b0;
      grant_reg   = fifo_reg[0];
      grant_data  = fifo_data[0];
      wait_next   = wait_cnt;

      if (state == FORCE) begin
         grant_valid = 1'b1;
         pop         = 1'b1;
      end else if (bus.i_WB_reg_write) begin
         grant_valid = 1'b1;
         grant_pipe  = 1'b1;
         grant_reg   = bus.i_WB_selected_reg;
         grant_data  = bus.i_WB_selected_data;
      end else if (count != 2'd0) begin
         grant_valid = 1'b1;
         pop         = 1'b1;
      end

      count_next = count + {1'b0, push} - {1'b0, pop};
      // A push lands in slot 1 only when one entry stays put this cycle.
      wr_hi      = count[0] & ~pop;

      if (pop)
         wait_next = 8'd0;
      else if (state == PENDING && grant_pipe)
         wait_next = wait_cnt + 8'd1;

      case (state)
         IDLE:    if (push) state_next = PENDING;
         PENDING: begin
            if (grant_pipe && wait_cnt == WAIT_LAST)
               state_next = FORCE;
            else if (count_next == 2'd0)
               state_next = IDLE;
         end
         FORCE:   state_next = (count_next != 2'd0) ? PENDING : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state        <= IDLE;
         count        <= 2'd0;
         wait_cnt     <= 8'd0;
         fifo_reg[0]  <= '0;
         fifo_reg[1]  <= '0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         rf_write_q   <= 1'b0;
         rf_reg_q     <= '0;
         rf_data_q    <= '0;
         pipe_stall_q <= 1'b0;
      end else begin
         state    <= state_next;
         count    <= count_next;
         wait_cnt <= wait_next;
         if (pop) begin
            fifo_reg[0]  <= fifo_reg[1];
            fifo_data[0] <= fifo_data[1];
         end
         if (push) begin
            if (wr_hi) begin
               fifo_reg[1]  <= bus.i_dbg_reg;
               fifo_data[1] <= bus.i_dbg_data;
            end else begin
               fifo_reg[0]  <= bus.i_dbg_reg;
               fifo_data[0] <= bus.i_dbg_data;
            end
         end
         // Register 0 is hardwired: the grant is consumed but never written.
         rf_write_q <= grant_valid && (grant_reg != '0);
         if (grant_valid) begin
            rf_reg_q  <= grant_reg;
            rf_data_q <= grant_data;
         end
         pipe_stall_q <= (state_next == FORCE);
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_regfile_wr_arbiter;

   localparam int NB_DATA  = 32;
   localparam int NB_REG   = 5;
   localparam int MAX_WAIT = 8;

   logic       clk;
   logic       rst;
   logic [1:0] fsm_state;

   regfile_wr_arbiter_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) bus ();

   regfile_wr_arbiter #(
      .NB_DATA(NB_DATA), .NB_REG(NB_REG), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .bus         (bus.slave),
      .o_fsm_state (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: buffered debug writes, starvation count, stall flag.
   logic [NB_REG+NB_DATA-1:0] exp_q[$];
   int                        m_wait;
   bit                        m_force;
   logic                      e_write;
   logic [NB_REG-1:0]         e_reg;
   logic [NB_DATA-1:0]        e_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_wait  = 0;
      m_force = 0;
      e_write = 1'b0;
      e_reg   = '0;
      e_data  = '0;
   endtask

   // One clock cycle: drive inputs, advance the model, check after the edge.
   task automatic step(input logic wb, input logic [NB_REG-1:0] wreg,
                       input logic [NB_DATA-1:0] wdata, input logic dv,
                       input logic [NB_REG-1:0] dreg, input logic [NB_DATA-1:0] ddata);
      bit                 pu, g, gpipe, popped, pending, nxt_force;
      logic [NB_REG-1:0]  greg;
      logic [NB_DATA-1:0] gdata;
      bus.i_WB_reg_write     = wb;
      bus.i_WB_selected_reg  = wreg;
      bus.i_WB_selected_data = wdata;
      bus.i_dbg_valid        = dv;
      bus.i_dbg_reg          = dreg;
      bus.i_dbg_data         = ddata;

      pu      = dv && (exp_q.size() < 2);
      pending = (exp_q.size() > 0) && !m_force;
      g = 0; gpipe = 0; popped = 0; greg = '0; gdata = '0;
      if (m_force) begin
         g = 1; popped = 1; {greg, gdata} = exp_q.pop_front();
      end else if (wb) begin
         g = 1; gpipe = 1; greg = wreg; gdata = wdata;
      end else if (exp_q.size() > 0) begin
         g = 1; popped = 1; {greg, gdata} = exp_q.pop_front();
      end
      nxt_force = pending && gpipe && (m_wait + 1 == MAX_WAIT - 1);
      if (popped) m_wait = 0;
      else if (pending && gpipe) m_wait++;
      if (pu) exp_q.push_back({dreg, ddata});
      m_force = nxt_force;
      e_write = g && (greg != '0);
      if (g) begin
         e_reg  = greg;
         e_data = gdata;
      end

      @(posedge clk);
      #1;
      chk("rf_write", 64'(bus.o_rf_write), 64'(e_write));
      chk("pipe_stall", 64'(bus.o_pipe_stall), 64'(m_force));
      chk("dbg_ready", 64'(bus.o_dbg_ready), 64'(exp_q.size() < 2));
      if (e_write) begin
         chk("rf_reg", 64'(bus.o_rf_reg), 64'(e_reg));
         chk("rf_data", 64'(bus.o_rf_data), 64'(e_data));
      end
   endtask

   task automatic idle_step();
      step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.i_WB_reg_write = 1'b0; bus.i_WB_selected_reg = '0; bus.i_WB_selected_data = '0;
      bus.i_dbg_valid = 1'b0; bus.i_dbg_reg = '0; bus.i_dbg_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int guard;
      rst = 1'b0;
      bus.i_WB_reg_write = 1'b0; bus.i_WB_selected_reg = '0; bus.i_WB_selected_data = '0;
      bus.i_dbg_valid = 1'b0; bus.i_dbg_reg = '0; bus.i_dbg_data = '0;
      #3;
      rst = 1'b1;
      #4;
      chk("reset_rf_write", 64'(bus.o_rf_write), 64'd0);
      chk("reset_rf_reg", 64'(bus.o_rf_reg), 64'd0);
      chk("reset_rf_data", 64'(bus.o_rf_data), 64'd0);
      chk("reset_stall", 64'(bus.o_pipe_stall), 64'd0);
      chk("reset_ready", 64'(bus.o_dbg_ready), 64'd1);
      apply_reset();

      // Pipeline write to r3, then a write to r0 that must be suppressed.
      step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
      chk("pipe_r3_write", 64'(bus.o_rf_write), 64'd1);
      chk("pipe_r3_reg", 64'(bus.o_rf_reg), 64'd3);
      chk("pipe_r3_data", 64'(bus.o_rf_data), 64'h11);
      step(1'b1, 5'd0, 32'h22, 1'b0, '0, '0);
      chk("pipe_r0_write", 64'(bus.o_rf_write), 64'd0);
      idle_step();
      chk("idle_hold_reg", 64'(bus.o_rf_reg), 64'd0);
      chk("idle_hold_data", 64'(bus.o_rf_data), 64'h22);

      // Two debug writes with the pipeline idle: emitted in order.
      step(1'b0, '0, '0, 1'b1, 5'd5, 32'hA);
      chk("dbg_first_nowrite", 64'(bus.o_rf_write), 64'd0);
      step(1'b0, '0, '0, 1'b1, 5'd6, 32'hB);
      chk("dbg_emit_5", 64'(bus.o_rf_reg), 64'd5);
      idle_step();
      chk("dbg_emit_6", 64'(bus.o_rf_reg), 64'd6);
      chk("dbg_emit_6_data", 64'(bus.o_rf_data), 64'hB);
      idle_step();

      // Full buffer under pipeline pressure: third push refused.
      step(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h70);
      step(1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'h80);
      chk("full_ready", 64'(bus.o_dbg_ready), 64'd0);
      step(1'b1, 5'd1, 32'h102, 1'b1, 5'd9, 32'h90);
      chk("full_keep2", 64'(exp_q.size()), 64'd2);
      repeat (12) idle_step();
      chk("full_drained_ready", 64'(bus.o_dbg_ready), 64'd1);

      // Starvation: one pending debug write, pipeline busy every cycle.
      apply_reset();
      step(1'b1, 5'd2, 32'h200, 1'b1, 5'd9, 32'h99);
      for (int i = 1; i <= 7; i++) begin
         step(1'b1, 5'd2, 32'(32'h200 + i), 1'b0, '0, '0);
         chk("starve_stall", 64'(bus.o_pipe_stall), 64'(i == 7));
      end
      step(1'b1, 5'd2, 32'h2FF, 1'b0, '0, '0);
      chk("force_dbg_reg", 64'(bus.o_rf_reg), 64'd9);
      chk("force_dbg_data", 64'(bus.o_rf_data), 64'h99);
      chk("force_one_cycle", 64'(bus.o_pipe_stall), 64'd0);
      step(1'b1, 5'd2, 32'h2FF, 1'b0, '0, '0);
      chk("resume_reg", 64'(bus.o_rf_reg), 64'd2);
      chk("resume_data", 64'(bus.o_rf_data), 64'h2FF);

      // Reset in FORCE with two entries buffered.
      apply_reset();
      step(1'b1, 5'd4, 32'h400, 1'b1, 5'd10, 32'hAA);
      step(1'b1, 5'd4, 32'h401, 1'b1, 5'd11, 32'hBB);
      guard = 0;
      while (!m_force && guard < 20) begin
         step(1'b1, 5'd4, 32'h402, 1'b0, '0, '0);
         guard++;
      end
      chk("reach_force", 64'(bus.o_pipe_stall), 64'd1);
      chk("force_two_held", 64'(bus.o_dbg_ready), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("midreset_write", 64'(bus.o_rf_write), 64'd0);
      chk("midreset_reg", 64'(bus.o_rf_reg), 64'd0);
      chk("midreset_data", 64'(bus.o_rf_data), 64'd0);
      chk("midreset_stall", 64'(bus.o_pipe_stall), 64'd0);
      chk("midreset_ready", 64'(bus.o_dbg_ready), 64'd1);
      bus.i_WB_reg_write = 1'b0;
      bus.i_dbg_valid    = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (4) idle_step();

      // Random traffic with alternating light and heavy pipeline load.
      for (int ph = 0; ph < 6; ph++) begin
         int wb_pct;
         wb_pct = (ph % 2 == 0) ? 35 : 95;
         for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 99) < wb_pct,
                 NB_REG'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 99) < 50,
                 NB_REG'($urandom_range(0, 31)), $urandom);
         end
      end
      repeat (6) idle_step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter NB_DATA, default 32: register data width.
REQ-002 Parameter NB_REG, default 5: register address width.
REQ-003 Parameter MAX_WAIT, default 8: pipeline-won cycles a pending debug write tolerates before forcing a stall; legal range 2..255.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL be cleared on reset assertion, independent of the clock.
REQ-005 i_clock  in  1  clock; all state SHALL update on its rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_WB_reg_write  in  1  pipeline write-back request.
REQ-008 i_WB_selected_reg  in  NB_REG  pipeline destination register.
REQ-009 i_WB_selected_data  in  NB_DATA  pipeline write data.
REQ-010 i_dbg_valid  in  1  debug-unit write request.
REQ-011 i_dbg_reg  in  NB_REG  debug destination register.
REQ-012 i_dbg_data  in  NB_DATA  debug write data.
REQ-013 o_dbg_ready  out  1  debug buffer can accept a write.
REQ-014 o_rf_write  out  1  register-file write enable, registered.
REQ-015 o_rf_reg  out  NB_REG  register-file write address, registered.
REQ-016 o_rf_data  out  NB_DATA  register-file write data, registered.
REQ-017 o_pipe_stall  out  1  pipeline freeze request, registered.

Function
REQ-018 Debug writes SHALL pass through a 2-entry FIFO; a push SHALL occur when i_dbg_valid=1 and o_dbg_ready=1.
REQ-019 o_dbg_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries; a pop in the same cycle SHALL NOT raise ready for that cycle.
REQ-020 The FSM SHALL have 3 states: IDLE (FIFO empty), PENDING (FIFO non-empty), FORCE (stall cycle).
REQ-021 Per-cycle grant: in FORCE, the FIFO head; else if i_WB_reg_write=1, the pipeline; else if the FIFO is non-empty, the FIFO head; else no grant.
REQ-022 A granted FIFO head SHALL be popped in that cycle.
REQ-023 The granted request SHALL appear on o_rf_write/o_rf_reg/o_rf_data one cycle later.
REQ-024 Any grant whose destination is register 0 SHALL produce o_rf_write=0; a debug entry targeting register 0 SHALL still be popped.
REQ-025 When no request is granted, o_rf_write SHALL be 0 and o_rf_reg/o_rf_data SHALL hold their previous values.
REQ-026 An 8-bit wait counter SHALL increment in each PENDING cycle in which the pipeline wins the grant, and SHALL clear on every debug pop.
REQ-027 PENDING SHALL go to FORCE at the clock edge where the counter reaches MAX_WAIT-1 while the pipeline wins.
REQ-028 o_pipe_stall SHALL be 1 during, and only during, FORCE cycles; FORCE SHALL last exactly one cycle.
REQ-029 In FORCE, the pipeline request SHALL be ignored; the frozen pipeline re-presents it in the next cycle.
REQ-030 FORCE SHALL exit to PENDING if the FIFO remains non-empty after the pop, else to IDLE; the counter SHALL be cleared.
REQ-031 IDLE SHALL go to PENDING on any push; PENDING SHALL go to IDLE when a pop empties the FIFO with no simultaneous push.
REQ-032 A simultaneous push and pop SHALL keep the occupancy unchanged and preserve FIFO order.

Reset
REQ-033 On reset: FSM=IDLE, FIFO empty, counter=0, o_rf_write=0, o_rf_reg=0, o_rf_data=0, o_pipe_stall=0, o_dbg_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard all buffered debug writes without emitting them.

Verification
REQ-035 Pipeline write reg 3 data 0x11, no debug traffic -> next cycle o_rf_write=1, o_rf_reg=3, o_rf_data=0x11; o_pipe_stall stays 0.
REQ-036 Pipeline writes reg 0 -> o_rf_write=0.
REQ-037 Debug pushes (5,0xA) and (6,0xB) with the pipeline idle -> writes emitted in order on consecutive cycles; o_dbg_ready=0 only while 2 entries are held.
REQ-038 Pipeline writes every cycle; one debug write is pending; MAX_WAIT=8 -> o_pipe_stall=1 for exactly one cycle after 7 pipeline grants, the debug write is emitted one cycle later, and the pipeline then resumes.
REQ-039 FIFO full and a third push attempted -> push refused (o_dbg_ready=0); no entry is lost or duplicated.
REQ-040 Reset asserted while in FORCE with 2 entries buffered -> all outputs take their REQ-033 values immediately; no buffered write is emitted after reset release.
